// File: rtl/baccarat_pkg.sv
// Shared baccarat constants, FSM state encoding and card point helper.
package baccarat_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CARD_W  = 4;

  // A hand total of NATURAL_MIN or more (up to MAX_POINT) ends the deal at once
  localparam logic [SCORE_W-1:0] NATURAL_MIN = SCORE_W'(8);
  localparam logic [SCORE_W-1:0] MAX_POINT   = SCORE_W'(9);
  // Player draws a third card on a total at or below DRAW_MAX
  localparam logic [SCORE_W-1:0] DRAW_MAX    = SCORE_W'(5);

  typedef enum logic [3:0] {
    DEAL_P1    = 4'd0,
    DEAL_D1    = 4'd1,
    DEAL_P2    = 4'd2,
    DEAL_D2    = 4'd3,
    CHECK      = 4'd4,
    DEAL_P3    = 4'd5,
    BANKER_CHK = 4'd6,
    DEAL_D3    = 4'd7,
    RESULT     = 4'd8,
    DONE       = 4'd9
  } state_t;

  // Point value of a raw card: A..9 count face value, 10/J/Q/K and no-card count 0
  function automatic logic [SCORE_W-1:0] card_value(input logic [CARD_W-1:0] card);
    if ((card >= CARD_W'(1)) && (card <= CARD_W'(9))) begin
      return SCORE_W'(card);
    end
    return SCORE_W'(0);
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card draw table, purely combinational.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] p3v,
  output logic       dealer_draw
);

  // Draw decision from banker total and the player's third-card point value
  always_comb begin
    dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (p3v != 4'd8);
      4'd4:             dealer_draw = (p3v >= 4'd2) && (p3v <= 4'd7);
      4'd5:             dealer_draw = (p3v >= 4'd4) && (p3v <= 4'd7);
      4'd6:             dealer_draw = (p3v >= 4'd6) && (p3v <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_fsm.sv
// Sequences one baccarat hand: card load strobes, third-card rules, win lights.
module deal_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_t     state;
  state_t     next_state;
  logic [3:0] p3v;
  logic       dealer_draw;
  logic       p_natural;
  logic       d_natural;

  assign p3v       = card_value(pcard3);
  assign p_natural = (pscore >= NATURAL_MIN) && (pscore <= MAX_POINT);
  assign d_natural = (dscore >= NATURAL_MIN) && (dscore <= MAX_POINT);

  banker_rule u_banker_rule (
    .dscore      (dscore),
    .p3v         (p3v),
    .dealer_draw (dealer_draw)
  );

  // State register; lights latch on the edge leaving RESULT and hold until reset
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= DEAL_P1;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RESULT) begin
        player_win_light <= (pscore >= dscore);
        dealer_win_light <= (dscore >= pscore);
      end
    end
  end

  // Next-state selection and one-hot Moore load strobes
  always_comb begin
    next_state  = state;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state)
      DEAL_P1: begin
        load_pcard1 = 1'b1;
        next_state  = DEAL_D1;
      end
      DEAL_D1: begin
        load_dcard1 = 1'b1;
        next_state  = DEAL_P2;
      end
      DEAL_P2: begin
        load_pcard2 = 1'b1;
        next_state  = DEAL_D2;
      end
      DEAL_D2: begin
        load_dcard2 = 1'b1;
        next_state  = CHECK;
      end
      CHECK: begin
        if (p_natural || d_natural) begin
          next_state = RESULT;
        end else if (pscore <= DRAW_MAX) begin
          next_state = DEAL_P3;
        end else if (dscore <= DRAW_MAX) begin
          next_state = DEAL_D3;
        end else begin
          next_state = RESULT;
        end
      end
      DEAL_P3: begin
        load_pcard3 = 1'b1;
        next_state  = BANKER_CHK;
      end
      BANKER_CHK: begin
        next_state = dealer_draw ? DEAL_D3 : RESULT;
      end
      DEAL_D3: begin
        load_dcard3 = 1'b1;
        next_state  = RESULT;
      end
      RESULT: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = DEAL_P1;
      end
    endcase
  end

endmodule
